// File: rtl/fsm_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_control_pkg
// Description : State encoding and threshold-pair indices for fsm_control_param.
// Revision    : 1.0  initial release
// ============================================================================
package fsm_control_pkg;

    localparam logic [4:0] ST_RESET  = 5'b00001;
    localparam logic [4:0] ST_INIT   = 5'b00010;
    localparam logic [4:0] ST_IDLE   = 5'b00100;
    localparam logic [4:0] ST_ACTIVE = 5'b01000;
    localparam logic [4:0] ST_ERROR  = 5'b10000;

    typedef enum logic [4:0] {
        S_RESET  = ST_RESET,
        S_INIT   = ST_INIT,
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_ERROR  = ST_ERROR
    } state_e;

    localparam int UMB_MF = 0;
    localparam int UMB_VC = 1;
    localparam int UMB_D  = 2;

endpackage : fsm_control_pkg
`default_nettype wire

// File: rtl/umbral_latch.sv
`default_nettype none
// ============================================================================
// Module      : umbral_latch
// Description : One threshold pair; loads alto/bajo only when alto >= bajo.
// Revision    : 1.0  initial release
// ============================================================================
module umbral_latch #(
    parameter int UMB_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [UMB_W-1:0] alto_in,
    input  logic [UMB_W-1:0] bajo_in,
    output logic [UMB_W-1:0] alto_out,
    output logic [UMB_W-1:0] bajo_out,
    output logic             cfg_err_out
);

    logic [UMB_W-1:0] alto_q, alto_d;
    logic [UMB_W-1:0] bajo_q, bajo_d;
    logic             cfg_err_q, cfg_err_d;

    // A rejected pair keeps the last good values so the FIFOs never see an
    // inverted window.
    always_comb begin
        alto_d    = alto_q;
        bajo_d    = bajo_q;
        cfg_err_d = cfg_err_q;
        if (load_en) begin
            if (alto_in >= bajo_in) begin
                alto_d    = alto_in;
                bajo_d    = bajo_in;
                cfg_err_d = 1'b0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alto_q    <= '0;
            bajo_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            alto_q    <= alto_d;
            bajo_q    <= bajo_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign alto_out    = alto_q;
    assign bajo_out    = bajo_q;
    assign cfg_err_out = cfg_err_q;

endmodule : umbral_latch
`default_nettype wire

// File: rtl/fsm_control_param.sv
`default_nettype none
// ============================================================================
// Module      : fsm_control_param
// Description : Parametrised FIFO-fabric controller: threshold load, status.
// Revision    : 1.0  initial release
// ============================================================================
module fsm_control_param
    import fsm_control_pkg::*;
#(
    parameter int N_FIFOS = 5,
    parameter int UMB_W   = 5,
    parameter int N_UMB   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic                     error_clear,
    input  logic [N_UMB*UMB_W-1:0]   umbral_alto,
    input  logic [N_UMB*UMB_W-1:0]   umbral_bajo,
    input  logic [N_FIFOS-1:0]       fifo_empties,
    input  logic [N_FIFOS-1:0]       fifo_errors,
    output logic [N_UMB*UMB_W-1:0]   umbral_alto_interno,
    output logic [N_UMB*UMB_W-1:0]   umbral_bajo_interno,
    output logic [N_UMB-1:0]         cfg_err_out,
    output logic                     error_out,
    output logic [N_FIFOS-1:0]       errors_out,
    output logic                     active_out,
    output logic                     idle_out
);

    state_e               state_q, state_d;
    logic [N_FIFOS-1:0]   errors_q, errors_d;
    logic                 any_err;
    logic                 all_empty;
    logic                 load_en;

    assign any_err   = |fifo_errors;
    assign all_empty = &fifo_empties;
    assign load_en   = (state_q == S_INIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT: begin
                if (any_err)    state_d = S_ERROR;
                else if (!init) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (any_err)         state_d = S_ERROR;
                else if (init)       state_d = S_INIT;
                else if (!all_empty) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (any_err)        state_d = S_ERROR;
                else if (init)      state_d = S_INIT;
                else if (all_empty) state_d = S_IDLE;
            end
            S_ERROR: begin
                if (error_clear && !any_err) state_d = S_INIT;
            end
            default:  state_d = S_RESET;
        endcase

        // Sticky error record accumulates only while staying in ERROR.
        errors_d = '0;
        if (state_d == S_ERROR) begin
            errors_d = ((state_q == S_ERROR) ? errors_q : '0) | fifo_errors;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_RESET;
            errors_q <= '0;
        end else begin
            state_q  <= state_d;
            errors_q <= errors_d;
        end
    end

    for (genvar i = 0; i < N_UMB; i++) begin : g_umb
        umbral_latch #(
            .UMB_W (UMB_W)
        ) u_latch (
            .clk         (clk),
            .reset       (reset),
            .load_en     (load_en),
            .alto_in     (umbral_alto[i*UMB_W +: UMB_W]),
            .bajo_in     (umbral_bajo[i*UMB_W +: UMB_W]),
            .alto_out    (umbral_alto_interno[i*UMB_W +: UMB_W]),
            .bajo_out    (umbral_bajo_interno[i*UMB_W +: UMB_W]),
            .cfg_err_out (cfg_err_out[i])
        );
    end

    assign error_out  = (state_q == S_ERROR);
    assign active_out = (state_q == S_ACTIVE);
    assign idle_out   = (state_q == S_IDLE);
    assign errors_out = errors_q;

endmodule : fsm_control_param
`default_nettype wire
